fabric_fire_collector: RTL and testbench
========================================

Name: fabric_fire_collector

Overview:
- Sink side of the assertion-checker fabric: gathers the single-bit fire outputs of up to NUM_CHK wrapped checkers and converts them into a queued stream of violation events (checker ID plus optional timestamp).
- Gates collection on configuration validity, with a settle window after each reconfiguration.
- Keeps per-checker sticky status for host polling.

Parameters:
- NUM_CHK, 16, number of checker fire inputs (2..64).
- FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2).
- SETTLE_CYC, 3, cycles to ignore fires after cfg_valid rises (>= 1).
- TS_W, 16, timestamp width.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- enable  input  1  collection enable.
- cfg_valid  input  1  fabric configuration valid; low = reconfiguring.
- fire_in  input  NUM_CHK  per-checker fire, level-sampled each cycle.
- clear_sticky  input  1  one-cycle pulse; clears sticky_status and overflow.
- evt_valid  output  1  event available.
- evt_ready  input  1  consumer accepts event.
- evt_id  output  clog2(NUM_CHK)  checker index of head event.
- evt_ts  output  TS_W  timestamp of head event.
- sticky_status  output  NUM_CHK  checkers that fired since the last clear.
- overflow  output  1  at least one fire coalesced (event lost) since the last clear.
- armed  output  1  collector in ARMED state.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pending=0, FIFO empty, evt_valid=0, evt_id=0, evt_ts=0, sticky_status=0, overflow=0, armed=0, timestamp counter=0, settle counter=0.
- State machine:
  - IDLE -> SETTLE when enable & cfg_valid; settle counter loads SETTLE_CYC-1.
  - SETTLE: counter decrements each cycle; at 0 with enable & cfg_valid still high -> ARMED.
  - ARMED -> IDLE when enable or cfg_valid drops.
  - SETTLE -> IDLE when enable or cfg_valid drops.
  - Net effect: ARMED is reached exactly SETTLE_CYC cycles after the first cycle enable & cfg_valid is seen high.
- Sampling:
  - Only in ARMED: pending |= fire_in, sticky_status |= fire_in, registered next cycle.
  - fire_in is ignored in IDLE/SETTLE.
  - Leaving ARMED clears pending. FIFO contents are retained and keep draining.
- Coalescing:
  - A fire on a bit already pending and not being issued this cycle sets overflow (sticky).
- Issue:
  - Each cycle, if pending != 0 and FIFO not full, the lowest set pending index is pushed with the current timestamp and its pending bit cleared.
  - Maximum one push per cycle.
  - If that same bit fires in the same cycle, set wins: the bit stays pending and a second event is issued later. No overflow in this case.
- Latency: fire_in high at cycle N (ARMED, FIFO empty, no lower pending bit) -> evt_valid high at N+2, with evt_ts = counter value at N+1.
- FIFO and handshake:
  - Pop on evt_valid & evt_ready. evt_id/evt_ts are stable while evt_valid & !evt_ready.
  - Push and pop in the same cycle are both allowed, including when full; a pop frees a slot for the same-cycle push.
  - FIFO full: pending holds. Nothing is dropped except through coalescing.
- Timestamp: free-running TS_W counter, increments every cycle from reset, wraps from all-ones to 0 silently.
- clear_sticky vs. new fire in the same cycle: the new fire wins (bit remains set); overflow is cleared unless a new coalesce occurs that cycle.
- armed output = (state == ARMED), registered.

Optional Feature:
- Macro FIRE_TIMESTAMP_EN.
- Defined: timestamp counter present; each FIFO entry stores TS_W bits; evt_ts as above.
- Undefined: no counter and no timestamp storage; evt_ts tied to 0; all other behaviour identical.

Decomposition:
- Package fabric_fire_pkg holds:
  - collector state enum (IDLE, SETTLE, ARMED);
  - ID-width helper function;
  - event struct {id, ts}.
- Sub-module fabric_fire_fifo: synchronous FIFO, parameterised width/depth, with simultaneous push/pop at full; instantiated once.
- Priority encoder stays inline.

Test Plan:
- Reset, arm, single fire: rst 2 cycles, enable=cfg_valid=1, SETTLE_CYC=3 -> armed high 3 cycles later; pulse fire_in[5] -> evt_valid 2 cycles later, evt_id=5, sticky_status=0x0020.
- Settle masking: fire_in[2] asserted during SETTLE -> no event, sticky_status stays 0; cfg_valid drop in ARMED -> armed=0 next cycle, pending cleared.
- Multi-fire ordering: fire_in=0x8101 in one cycle, evt_ready=1 -> events 0, 8, 15 on consecutive cycles.
- Backpressure/full: evt_ready=0, fire bits 0..5 pulsed -> 4 events queued, bits 4 and 5 held pending; refire bit 4 -> overflow=1; release ready -> events 0,1,2,3,4,5 in order, none lost except the coalesced one.
- Set-wins race: bit 3 pending and being issued while fire_in[3] high -> two events with id 3; overflow stays 0.
- Clear and timestamp wrap (FIRE_TIMESTAMP_EN, TS_W=4): fire at counter 15 -> next event ts wraps to 0; clear_sticky with simultaneous fire_in[1] -> sticky_status=0x0002.

Source files
------------

// File: rtl/fabric_fire_pkg.sv
// Shared types for the assertion-checker fire collector: collector state,
// ID-width helper and the violation event record.
package fabric_fire_pkg;

   // Collector state machine encoding
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ARMED  = 2'd2
   } coll_state_e;

   // Upper bounds for the event record fields (NUM_CHK <= 64, TS_W <= 32)
   localparam int EVT_ID_MAX_W = 6;
   localparam int EVT_TS_MAX_W = 32;

   // One violation event: checker index plus capture timestamp
   typedef struct packed {
      logic [EVT_ID_MAX_W-1:0] id;
      logic [EVT_TS_MAX_W-1:0] ts;
   } fire_evt_t;

   // Width needed to hold an index in 0..num_chk-1 (at least one bit)
   function automatic int fire_id_width(input int num_chk);
      int w;
      w = 1;
      while ((1 << w) < num_chk) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/fabric_fire_fifo.sv
// Synchronous event FIFO. A pop in the same cycle frees a slot for a push,
// so push+pop is accepted even when full. Storage is cleared on reset so the
// head word reads as zero while empty.
module fabric_fire_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             valid_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             empty_s, full_s, do_push_s, do_pop_s;

   assign empty_s    = (wr_q == rd_q);
   assign full_s     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop_s   = pop_i & ~empty_s;
   assign do_push_s  = push_i & (~full_s | do_pop_s);
   assign full_o     = full_s;
   assign valid_o    = ~empty_s;
   assign pop_data_o = mem_q[rd_q[AW-1:0]];

   // Pointer next-state from accepted push/pop
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push_s) begin
         wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_d = wr_q;
      end
      if (do_pop_s) begin
         rd_d = rd_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_d = rd_q;
      end
   end

   // Pointer and storage registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (do_push_s) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
         end
      end
   end

endmodule

// File: rtl/fabric_fire_collector.sv
// Fire collector: samples checker fire lines while ARMED, queues one event per
// cycle (lowest pending index first) and keeps sticky status for the host.
// Optional macro FIRE_TIMESTAMP_EN adds a free-running timestamp to events;
// without it evt_ts is tied to zero and no timestamp is stored.
module fabric_fire_collector
   import fabric_fire_pkg::*;
#(
   parameter int NUM_CHK    = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int SETTLE_CYC = 3,
   parameter int TS_W       = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              cfg_valid,
   input  logic [NUM_CHK-1:0]                fire_in,
   input  logic                              clear_sticky,
   output logic                              evt_valid,
   input  logic                              evt_ready,
   output logic [fire_id_width(NUM_CHK)-1:0] evt_id,
   output logic [TS_W-1:0]                   evt_ts,
   output logic [NUM_CHK-1:0]                sticky_status,
   output logic                              overflow,
   output logic                              armed
);

   localparam int ID_W  = fire_id_width(NUM_CHK);
   localparam int CNT_W = fire_id_width(SETTLE_CYC + 1);
`ifdef FIRE_TIMESTAMP_EN
   localparam int EVT_W = ID_W + TS_W;
`else
   localparam int EVT_W = ID_W;
`endif

   coll_state_e        state_q, state_d;
   logic [CNT_W-1:0]   settle_q, settle_d;
   logic [NUM_CHK-1:0] pending_q, pending_d;
   logic [NUM_CHK-1:0] sticky_q, sticky_d;
   logic               ovf_q, ovf_d;
   logic               armed_q;

   logic               go_s, pop_s, can_push_s, issue_s, coalesce_s;
   logic               fifo_full_s, fifo_valid_s;
   logic [ID_W-1:0]    iss_idx_s;
   logic [NUM_CHK-1:0] issue_mask_s, fire_s;
   logic [EVT_W-1:0]   push_data_s, pop_data_s;

`ifdef FIRE_TIMESTAMP_EN
   logic [TS_W-1:0]    ts_q;

   // Free-running timestamp, wraps silently
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   assign push_data_s = {iss_idx_s, ts_q};
   assign evt_ts      = pop_data_s[TS_W-1:0];
   assign evt_id      = pop_data_s[EVT_W-1 -: ID_W];
`else
   assign push_data_s = iss_idx_s;
   assign evt_ts      = '0;
   assign evt_id      = pop_data_s;
`endif

   assign go_s          = enable & cfg_valid;
   assign evt_valid     = fifo_valid_s;
   assign sticky_status = sticky_q;
   assign overflow      = ovf_q;
   assign armed         = armed_q;

   // Collector FSM next state; settle counter times the post-config window
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         IDLE: begin
            if (go_s) begin
               if (SETTLE_CYC == 1) begin
                  state_d = ARMED;
               end else begin
                  state_d  = SETTLE;
                  settle_d = CNT_W'(SETTLE_CYC - 1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         SETTLE: begin
            if (!go_s) begin
               state_d  = IDLE;
               settle_d = '0;
            end else begin
               settle_d = settle_q - CNT_W'(1);
               if (settle_q == CNT_W'(1)) begin
                  state_d = ARMED;
               end else begin
                  state_d = SETTLE;
               end
            end
         end
         ARMED: begin
            if (!go_s) begin
               state_d = IDLE;
            end else begin
               state_d = ARMED;
            end
         end
         default: begin
            state_d  = IDLE;
            settle_d = '0;
         end
      endcase
   end

   // Priority encoder: lowest set pending bit wins
   always_comb begin
      iss_idx_s = '0;
      for (int i = NUM_CHK - 1; i >= 0; i--) begin
         iss_idx_s = pending_q[i] ? ID_W'(i) : iss_idx_s;
      end
   end

   // Issue, coalescing and sticky/pending next-state; a same-cycle fire on
   // the issued bit re-arms it rather than counting as a loss
   always_comb begin
      pop_s        = fifo_valid_s & evt_ready;
      can_push_s   = ~fifo_full_s | pop_s;
      issue_s      = (|pending_q) & can_push_s;
      issue_mask_s = issue_s ? (NUM_CHK'(1) << iss_idx_s) : '0;
      fire_s       = (state_q == ARMED) ? fire_in : '0;
      coalesce_s   = |(fire_s & pending_q & ~issue_mask_s);
      if (state_d == ARMED) begin
         pending_d = (pending_q & ~issue_mask_s) | fire_s;
      end else begin
         pending_d = '0;
      end
      sticky_d = (clear_sticky ? '0 : sticky_q) | fire_s;
      ovf_d    = (clear_sticky ? 1'b0 : ovf_q) | coalesce_s;
   end

   // State, pending, sticky and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         settle_q  <= '0;
         pending_q <= '0;
         sticky_q  <= '0;
         ovf_q     <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         pending_q <= pending_d;
         sticky_q  <= sticky_d;
         ovf_q     <= ovf_d;
         armed_q   <= (state_d == ARMED);
      end
   end

   fabric_fire_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (issue_s),
      .push_data_i (push_data_s),
      .full_o      (fifo_full_s),
      .pop_i       (pop_s),
      .pop_data_o  (pop_data_s),
      .valid_o     (fifo_valid_s)
   );

endmodule

// File: tb/tb_fabric_fire_collector.sv
// Directed bench for fabric_fire_collector with a queued scoreboard: the
// stimulus thread pushes expected events, a negedge monitor pops and compares
// every accepted event.
module tb_fabric_fire_collector;
   import fabric_fire_pkg::*;

   logic        clk = 1'b0;
   logic        rst, enable, cfg_valid, clear_sticky, evt_ready;
   logic [15:0] fire_in;
   logic        evt_valid, overflow, armed;
   logic [3:0]  evt_id, evt_ts;
   logic [15:0] sticky_status;

   int n_checks = 0;
   int n_fail   = 0;

   fire_evt_t  exp_q [$];
   bit         ts_chk_q [$];
   logic [3:0] model_ts;

   fabric_fire_collector #(
      .NUM_CHK(16), .FIFO_DEPTH(4), .SETTLE_CYC(3), .TS_W(4)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid),
      .fire_in(fire_in), .clear_sticky(clear_sticky),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
      .evt_ts(evt_ts), .sticky_status(sticky_status), .overflow(overflow),
      .armed(armed)
   );

   always #5 clk = ~clk;

   // Reference timestamp: zero under reset, +1 per cycle, 4-bit wrap
   always @(posedge clk) begin
      if (rst) model_ts <= 4'd0;
      else     model_ts <= model_ts + 4'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Queue an expected event; ts_now is the counter value in the issue cycle
   task automatic expect_evt(input int id, input logic [3:0] ts_now, input bit chk_ts);
      fire_evt_t e;
      e    = '0;
      e.id = 6'(id);
`ifdef FIRE_TIMESTAMP_EN
      e.ts = 32'(ts_now);
`else
      e.ts = 32'(ts_now & 4'd0);
`endif
      exp_q.push_back(e);
      ts_chk_q.push_back(chk_ts);
   endtask

   // Monitor: every accepted event must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_evt: got id %0d, expected no event", evt_id);
         end else begin
            fire_evt_t e;
            bit        c;
            e = exp_q.pop_front();
            c = ts_chk_q.pop_front();
            chk("evt_id", 32'(evt_id), 32'(e.id));
            if (c) chk("evt_ts", 32'(evt_ts), e.ts);
         end
      end
   end

   initial begin
      rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; clear_sticky = 1'b0;
      evt_ready = 1'b0; fire_in = 16'h0000;
      ticks(2);
      // Reset state
      chk("rst_evt_valid", 32'(evt_valid), 32'd0);
      chk("rst_evt_id",    32'(evt_id),    32'd0);
      chk("rst_evt_ts",    32'(evt_ts),    32'd0);
      chk("rst_sticky",    32'(sticky_status), 32'd0);
      chk("rst_overflow",  32'(overflow),  32'd0);
      chk("rst_armed",     32'(armed),     32'd0);

      // Arm with a fire during the settle window
      rst = 1'b0; enable = 1'b1; cfg_valid = 1'b1;
      tick();
      chk("settle1_armed", 32'(armed), 32'd0);
      fire_in = 16'h0004;
      tick();
      fire_in = 16'h0000;
      chk("settle2_armed", 32'(armed), 32'd0);
      tick();
      chk("armed_after_3", 32'(armed), 32'd1);
      chk("settle_sticky", 32'(sticky_status), 32'd0);
      chk("settle_no_evt", 32'(evt_valid), 32'd0);

      // Single fire, latency and timestamp
      evt_ready = 1'b1;
      fire_in = 16'h0020;
      tick();
      fire_in = 16'h0000;
      expect_evt(5, model_ts, 1'b1);
      chk("single_sticky", 32'(sticky_status), 32'h0020);
      chk("single_valid_n1", 32'(evt_valid), 32'd0);
      tick();
      chk("single_valid_n2", 32'(evt_valid), 32'd1);
      ticks(3);

      // Multi-fire ordering
      fire_in = 16'h8101;
      tick();
      fire_in = 16'h0000;
      expect_evt(0, 4'd0, 1'b0);
      expect_evt(8, 4'd0, 1'b0);
      expect_evt(15, 4'd0, 1'b0);
      ticks(6);
      chk("multi_drained", 32'(exp_q.size()), 32'd0);

      // Backpressure, full FIFO and coalescing
      evt_ready = 1'b0;
      fire_in = 16'h003F;
      tick();
      fire_in = 16'h0000;
      ticks(6);
      chk("bp_valid", 32'(evt_valid), 32'd1);
      chk("bp_head_id", 32'(evt_id), 32'd0);
      chk("bp_no_ovf", 32'(overflow), 32'd0);
      fire_in = 16'h0010;
      tick();
      fire_in = 16'h0000;
      chk("bp_overflow", 32'(overflow), 32'd1);
      chk("bp_head_stable", 32'(evt_id), 32'd0);
      for (int i = 0; i < 6; i++) expect_evt(i, 4'd0, 1'b0);
      evt_ready = 1'b1;
      ticks(10);
      chk("bp_drained", 32'(exp_q.size()), 32'd0);
      chk("bp_empty", 32'(evt_valid), 32'd0);
      clear_sticky = 1'b1;
      tick();
      clear_sticky = 1'b0;
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_sticky", 32'(sticky_status), 32'd0);

      // Set-wins race on bit 3
      fire_in = 16'h0008;
      ticks(2);
      fire_in = 16'h0000;
      expect_evt(3, 4'd0, 1'b0);
      expect_evt(3, 4'd0, 1'b0);
      ticks(6);
      chk("race_overflow", 32'(overflow), 32'd0);
      chk("race_drained", 32'(exp_q.size()), 32'd0);

      // clear_sticky with a simultaneous fire
      clear_sticky = 1'b1;
      fire_in = 16'h0002;
      tick();
      clear_sticky = 1'b0;
      fire_in = 16'h0000;
      expect_evt(1, 4'd0, 1'b0);
      chk("clr_fire_sticky", 32'(sticky_status), 32'h0002);
      ticks(4);

      // Timestamp wrap: fire while counter is 15, issue sees 0
      for (int k = 0; k < 40 && model_ts != 4'd15; k++) tick();
      fire_in = 16'h0080;
      tick();
      fire_in = 16'h0000;
      expect_evt(7, model_ts, 1'b1);
      ticks(4);
      chk("wrap_drained", 32'(exp_q.size()), 32'd0);

      // Config drop in ARMED: pending cleared, FIFO contents still drain
      evt_ready = 1'b0;
      fire_in = 16'hFC00;
      tick();
      fire_in = 16'h0000;
      ticks(6);
      chk("drop_head_id", 32'(evt_id), 32'd10);
      cfg_valid = 1'b0;
      tick();
      chk("drop_armed", 32'(armed), 32'd0);
      for (int i = 10; i < 14; i++) expect_evt(i, 4'd0, 1'b0);
      evt_ready = 1'b1;
      ticks(8);
      chk("drop_drained", 32'(exp_q.size()), 32'd0);
      chk("drop_empty", 32'(evt_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
